// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and
// EX-stage forwarding select generation.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [31:0] id_ReadData1,
    input  logic [31:0] id_ReadData2,
    input  logic [31:0] id_imm,
    input  logic        id_RegWrite,
    input  logic        id_MemRead,
    input  logic        id_MemWrite,
    input  logic        id_ALUSrc,
    input  logic        id_RegDst,
    input  logic [3:0]  id_ALUOp,
    input  logic        flush,
    input  logic        mem_RegWrite,
    input  logic [4:0]  mem_WriteAddr,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_WriteAddr,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [31:0] ex_imm,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_ALUSrc,
    output logic [3:0]  ex_ALUOp,
    output logic [4:0]  ex_WriteAddr,
    output logic [1:0]  ex_fwdA,
    output logic [1:0]  ex_fwdB,
    output logic [15:0] stall_count
);

    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdMem = 2'b10;
    localparam logic [1:0] FwdWb  = 2'b01;

    logic       loadInEx;
    logic       rsHit;
    logic       rtHit;
    logic       hazard;
    logic       bubble;
    logic [4:0] idWriteAddr;

    // Load-use hazard: EX holds a load whose destination ID reads
    always_comb begin
        loadInEx = ex_valid & ex_MemRead & (ex_WriteAddr != 5'd0);
        rsHit    = id_uses_rs & (ex_WriteAddr == id_rs);
        rtHit    = id_uses_rt & (ex_WriteAddr == id_rt);
        hazard   = id_valid & loadInEx & (rsHit | rtHit);
        stall    = hazard & ~flush;
        bubble   = stall | flush;
        idWriteAddr = id_RegDst ? id_rd : id_rt;
    end

    // Pipeline register: capture ID, or insert a bubble on stall/flush
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            ex_A         <= 32'd0;
            ex_B         <= 32'd0;
            ex_imm       <= 32'd0;
            ex_RegWrite  <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= 4'd0;
            ex_WriteAddr <= 5'd0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= id_pc;
            ex_rs        <= 5'd0;
            ex_rt        <= 5'd0;
            ex_A         <= id_ReadData1;
            ex_B         <= id_ReadData2;
            ex_imm       <= id_imm;
            ex_RegWrite  <= 1'b0;
            ex_MemRead   <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= 4'd0;
            ex_WriteAddr <= 5'd0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_A         <= id_ReadData1;
            ex_B         <= id_ReadData2;
            ex_imm       <= id_imm;
            ex_RegWrite  <= id_RegWrite;
            ex_MemRead   <= id_MemRead;
            ex_MemWrite  <= id_MemWrite;
            ex_ALUSrc    <= id_ALUSrc;
            ex_ALUOp     <= id_ALUOp;
            ex_WriteAddr <= idWriteAddr;
        end
    end

    // Saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Operand forwarding selects; EX/MEM wins over MEM/WB, $0 never forwards
    always_comb begin
        ex_fwdA = FwdReg;
        ex_fwdB = FwdReg;
        if (mem_RegWrite && mem_WriteAddr != 5'd0 &&
            mem_WriteAddr == ex_rs) begin
            ex_fwdA = FwdMem;
        end else if (wb_RegWrite && wb_WriteAddr != 5'd0 &&
                     wb_WriteAddr == ex_rs) begin
            ex_fwdA = FwdWb;
        end
        if (mem_RegWrite && mem_WriteAddr != 5'd0 &&
            mem_WriteAddr == ex_rt) begin
            ex_fwdB = FwdMem;
        end else if (wb_RegWrite && wb_WriteAddr != 5'd0 &&
                     wb_WriteAddr == ex_rt) begin
            ex_fwdB = FwdWb;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: capture, load-use stall,
// flush priority, forwarding priority and reset behaviour.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        idValid;
    logic [31:0] idPc;
    logic [4:0]  idRs, idRt, idRd;
    logic        idUsesRs, idUsesRt;
    logic [31:0] idRd1, idRd2, idImm;
    logic        idRegWrite, idMemRead, idMemWrite, idAluSrc, idRegDst;
    logic [3:0]  idAluOp;
    logic        flush;
    logic        memRegWrite;
    logic [4:0]  memWriteAddr;
    logic        wbRegWrite;
    logic [4:0]  wbWriteAddr;
    logic        stall;
    logic        exValid;
    logic [31:0] exPc;
    logic [4:0]  exRs, exRt;
    logic [31:0] exA, exB, exImm;
    logic        exRegWrite, exMemRead, exMemWrite, exAluSrc;
    logic [3:0]  exAluOp;
    logic [4:0]  exWriteAddr;
    logic [1:0]  exFwdA, exFwdB;
    logic [15:0] stallCount;

    int nChecks = 0;
    int nErrors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(idValid), .id_pc(idPc),
        .id_rs(idRs), .id_rt(idRt), .id_rd(idRd),
        .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt),
        .id_ReadData1(idRd1), .id_ReadData2(idRd2), .id_imm(idImm),
        .id_RegWrite(idRegWrite), .id_MemRead(idMemRead),
        .id_MemWrite(idMemWrite), .id_ALUSrc(idAluSrc),
        .id_RegDst(idRegDst), .id_ALUOp(idAluOp),
        .flush(flush),
        .mem_RegWrite(memRegWrite), .mem_WriteAddr(memWriteAddr),
        .wb_RegWrite(wbRegWrite), .wb_WriteAddr(wbWriteAddr),
        .stall(stall),
        .ex_valid(exValid), .ex_pc(exPc), .ex_rs(exRs), .ex_rt(exRt),
        .ex_A(exA), .ex_B(exB), .ex_imm(exImm),
        .ex_RegWrite(exRegWrite), .ex_MemRead(exMemRead),
        .ex_MemWrite(exMemWrite), .ex_ALUSrc(exAluSrc),
        .ex_ALUOp(exAluOp), .ex_WriteAddr(exWriteAddr),
        .ex_fwdA(exFwdA), .ex_fwdB(exFwdB),
        .stall_count(stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearId();
        idValid = 1'b0; idPc = 32'd0;
        idRs = 5'd0; idRt = 5'd0; idRd = 5'd0;
        idUsesRs = 1'b0; idUsesRt = 1'b0;
        idRd1 = 32'd0; idRd2 = 32'd0; idImm = 32'd0;
        idRegWrite = 1'b0; idMemRead = 1'b0; idMemWrite = 1'b0;
        idAluSrc = 1'b0; idRegDst = 1'b0; idAluOp = 4'd0;
    endtask

    task automatic driveLoad(input logic [4:0] dst);
        clearId();
        idValid = 1'b1; idPc = 32'h100;
        idRs = 5'd1; idRt = dst; idUsesRs = 1'b1;
        idMemRead = 1'b1; idRegWrite = 1'b1; idAluSrc = 1'b1;
        idAluOp = 4'd2;
    endtask

    task automatic driveAdd(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd);
        clearId();
        idValid = 1'b1; idPc = 32'h104;
        idRs = rs; idRt = rt; idRd = rd;
        idUsesRs = 1'b1; idUsesRt = 1'b1;
        idRd1 = 32'hAAAA_0001; idRd2 = 32'hBBBB_0002;
        idRegWrite = 1'b1; idRegDst = 1'b1; idAluOp = 4'd2;
    endtask

    initial begin
        clearId();
        flush = 1'b0;
        memRegWrite = 1'b0; memWriteAddr = 5'd0;
        wbRegWrite = 1'b0; wbWriteAddr = 5'd0;

        // reset with everything asserted
        rst = 1'b1;
        idValid = 1'b1; idRegWrite = 1'b1; idMemRead = 1'b1;
        idMemWrite = 1'b1; idAluSrc = 1'b1; idRegDst = 1'b1;
        idAluOp = 4'hF; flush = 1'b1;
        tick();
        checkVal("rst_valid", {31'd0, exValid}, 32'd0);
        checkVal("rst_regwrite", {31'd0, exRegWrite}, 32'd0);
        checkVal("rst_count", {16'd0, stallCount}, 32'd0);
        checkVal("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0; flush = 1'b0;

        // pass-through capture
        clearId();
        idValid = 1'b1; idRd1 = 32'h1234_5678; idRd2 = 32'hCAFE_F00D;
        idRd = 5'd5; idRt = 5'd7; idRegDst = 1'b1; idRegWrite = 1'b1;
        idPc = 32'h40; idImm = 32'hFFFF_FFF0; idAluOp = 4'd6;
        #1;
        checkVal("pass_stall", {31'd0, stall}, 32'd0);
        tick();
        checkVal("pass_A", exA, 32'h1234_5678);
        checkVal("pass_B", exB, 32'hCAFE_F00D);
        checkVal("pass_waddr", {27'd0, exWriteAddr}, 32'd5);
        checkVal("pass_valid", {31'd0, exValid}, 32'd1);
        checkVal("pass_pc", exPc, 32'h40);
        checkVal("pass_aluop", {28'd0, exAluOp}, 32'd6);
        idRegDst = 1'b0;
        tick();
        checkVal("regdst0_waddr", {27'd0, exWriteAddr}, 32'd7);

        // load-use stall on rs
        driveLoad(5'd8);
        tick();
        checkVal("lw_memread", {31'd0, exMemRead}, 32'd1);
        checkVal("lw_waddr", {27'd0, exWriteAddr}, 32'd8);
        driveAdd(5'd8, 5'd9, 5'd10);
        #1;
        checkVal("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkVal("lu_bubble", {31'd0, exValid}, 32'd0);
        checkVal("lu_bubble_wr", {31'd0, exRegWrite}, 32'd0);
        checkVal("lu_count", {16'd0, stallCount}, 32'd1);
        checkVal("lu_stall_drop", {31'd0, stall}, 32'd0);
        tick();
        checkVal("lu_cap_valid", {31'd0, exValid}, 32'd1);
        checkVal("lu_cap_waddr", {27'd0, exWriteAddr}, 32'd10);
        checkVal("lu_cap_A", exA, 32'hAAAA_0001);
        checkVal("lu_count_hold", {16'd0, stallCount}, 32'd1);

        // load to $0 never stalls
        driveLoad(5'd0);
        tick();
        driveAdd(5'd0, 5'd0, 5'd11);
        #1;
        checkVal("ld0_stall", {31'd0, stall}, 32'd0);

        // matching rt that the instruction does not read
        driveLoad(5'd8);
        tick();
        driveAdd(5'd2, 5'd8, 5'd12);
        idUsesRt = 1'b0;
        #1;
        checkVal("unused_rt_stall", {31'd0, stall}, 32'd0);
        idUsesRt = 1'b1;
        #1;
        checkVal("used_rt_stall", {31'd0, stall}, 32'd1);
        idUsesRt = 1'b0;
        tick();

        // rs = rt = load destination stalls exactly once
        driveLoad(5'd8);
        tick();
        driveAdd(5'd8, 5'd8, 5'd13);
        #1;
        checkVal("rsrt_stall", {31'd0, stall}, 32'd1);
        tick();
        checkVal("rsrt_stall_once", {31'd0, stall}, 32'd0);
        checkVal("rsrt_count", {16'd0, stallCount}, 32'd2);
        tick();
        checkVal("rsrt_cap", {27'd0, exWriteAddr}, 32'd13);

        // flush overrides a hazard
        driveLoad(5'd8);
        tick();
        driveAdd(5'd8, 5'd9, 5'd14);
        idMemWrite = 1'b1;
        flush = 1'b1;
        #1;
        checkVal("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        checkVal("flush_valid", {31'd0, exValid}, 32'd0);
        checkVal("flush_memwrite", {31'd0, exMemWrite}, 32'd0);
        checkVal("flush_count", {16'd0, stallCount}, 32'd2);
        flush = 1'b0;

        // forwarding priority
        driveAdd(5'd3, 5'd4, 5'd15);
        tick();
        memRegWrite = 1'b1; memWriteAddr = 5'd3;
        wbRegWrite = 1'b1; wbWriteAddr = 5'd3;
        #1;
        checkVal("fwdA_mem", {30'd0, exFwdA}, 32'd2);
        checkVal("fwdB_none", {30'd0, exFwdB}, 32'd0);
        memRegWrite = 1'b0;
        #1;
        checkVal("fwdA_wb", {30'd0, exFwdA}, 32'd1);
        wbWriteAddr = 5'd4;
        memRegWrite = 1'b1; memWriteAddr = 5'd4;
        #1;
        checkVal("fwdB_mem", {30'd0, exFwdB}, 32'd2);
        checkVal("fwdA_off", {30'd0, exFwdA}, 32'd0);
        memRegWrite = 1'b0;
        #1;
        checkVal("fwdB_wb", {30'd0, exFwdB}, 32'd1);
        driveAdd(5'd0, 5'd4, 5'd16);
        tick();
        memRegWrite = 1'b1; memWriteAddr = 5'd0;
        wbRegWrite = 1'b1; wbWriteAddr = 5'd0;
        #1;
        checkVal("fwdA_zero", {30'd0, exFwdA}, 32'd0);
        memRegWrite = 1'b0; wbRegWrite = 1'b0;

        // reset during a stall cancels it
        driveLoad(5'd8);
        tick();
        driveAdd(5'd8, 5'd9, 5'd17);
        #1;
        checkVal("prerst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        tick();
        checkVal("rststall_valid", {31'd0, exValid}, 32'd0);
        checkVal("rststall_count", {16'd0, stallCount}, 32'd0);
        checkVal("rststall_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // flush with no valid ID instruction
        clearId();
        tick();
        flush = 1'b1;
        tick();
        checkVal("flush_idle_valid", {31'd0, exValid}, 32'd0);
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS pipeline. It captures the two operands read from the register file, together with the decoded controls and register addresses, on each clock. It also detects load-use hazards, generating a stall back to IF/ID and a bubble into EX, and produces EX-stage forwarding selects from the EX/MEM and MEM/WB destinations. It sits between the register file read ports and the EX stage ALU/operand muxes.

## Interface
- No parameters; data width is fixed at 32 bits and register address width at 5 bits.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  32  PC of the ID instruction
- id_rs, id_rt, id_rd  in  5 each  register fields
- id_uses_rs, id_uses_rt  in  1 each  instruction reads rs / rt
- id_ReadData1, id_ReadData2  in  32 each  register file outputs for rs / rt
- id_imm  in  32  sign/zero-extended immediate
- id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, id_RegDst  in  1 each  decoded controls
- id_ALUOp  in  4  ALU operation
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction
- mem_RegWrite  in  1; mem_WriteAddr  in  5  EX/MEM destination
- wb_RegWrite  in  1; wb_WriteAddr  in  5  MEM/WB destination
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_pc, ex_rs, ex_rt, ex_A, ex_B, ex_imm, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_ALUOp  out  registered copies for EX
- ex_WriteAddr  out  5  registered destination: id_RegDst ? id_rd : id_rt
- ex_fwdA, ex_fwdB  out  2 each  operand select: 00 register, 10 EX/MEM, 01 MEM/WB
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- Capture, with no stall and no flush: on the clock, every ex_* register loads its id_* source. ex_valid <= id_valid.
- Load-use hazard: `hz` = id_valid & ex_valid & ex_MemRead & (ex_WriteAddr != 0) & ((id_uses_rs & ex_WriteAddr == id_rs) | (id_uses_rt & ex_WriteAddr == id_rt)).
  - stall = hz & ~flush.
- Bubble: when stall or flush is asserted, the next clock loads a bubble.
  - ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite and ex_ALUOp load 0.
  - ex_WriteAddr loads 0.
  - Data, pc and address fields may load any value; they carry no meaning while ex_valid = 0.
- Stall length: a stall lasts exactly one cycle. After the bubble, EX no longer holds the load, so hz drops and the held ID instruction is captured on the following clock.
- Flush priority: flush overrides a hazard. stall is 0, a bubble is inserted and the ID instruction is discarded.
- Register-file writeback: the register file writes combinationally. A WB write in the same cycle as the ID read is therefore already visible on id_ReadData*, and this block adds no WB→ID bypass.
- Forwarding (combinational from registered ex_rs / ex_rt):
  - ex_fwdA = 10 if mem_RegWrite & mem_WriteAddr != 0 & mem_WriteAddr == ex_rs;
  - else 01 if wb_RegWrite & wb_WriteAddr != 0 & wb_WriteAddr == ex_rs;
  - else 00.
  - ex_fwdB uses the same rules with ex_rt.
  - EX/MEM has priority over MEM/WB. Register $0 never forwards.
- stall_count increments by 1 on each clock where stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (rst = 1 at a rising edge): all ex_* outputs go to 0, so ex_valid = 0, and stall_count = 0.
  - stall is combinational and is 0 while EX is invalid.
  - Reset overrides both flush and capture.
  - Reset during a stall cancels the pending stall; no instruction is replayed.
- Latency: an ID input appears on ex_* one clock later.
- Simultaneous events:
  - flush with hz: a bubble is inserted and stall = 0.
  - flush with id_valid = 0: a bubble is inserted.
  - Both mem and wb match the same ex_rs: select 10.
- Addresses: all comparisons are full 5-bit equality. rs = rt = the load destination stalls once, not twice.

## Test plan
- Reset: assert rst with id_valid = 1 and all controls = 1 → next cycle ex_valid = 0, ex_RegWrite = 0, stall_count = 0, stall = 0.
- Pass-through: id_ReadData1 = 32'h1234_5678, id_rd = 5, id_RegDst = 1, id_RegWrite = 1 → next cycle ex_A = 32'h1234_5678, ex_WriteAddr = 5, ex_valid = 1, stall = 0.
- Load-use stall:
  - Stimulus: lw to $8 in EX; ID holds an add with rs = 8 and id_uses_rs = 1.
  - Stall cycle: stall = 1 for exactly one cycle; the next ex_valid = 0; stall_count = 1.
  - Following cycle: the add is captured.
- Load to $0 or unused operand: load with WriteAddr = 0, or a matching rt with id_uses_rt = 0 → stall = 0.
- Flush over hazard: hz condition true together with flush = 1 → stall = 0, next ex_valid = 0, ex_MemWrite = 0.
- Forwarding priority:
  - ex_rs = 3 with mem_WriteAddr = 3 and wb_WriteAddr = 3, both RegWrite = 1 → ex_fwdA = 10.
  - Clear mem_RegWrite → ex_fwdA = 01.
  - Set ex_rs = 0 → ex_fwdA = 00.
